// File: rtl/pwm_bank_shadowed_if.sv
// Byte-wide register bus between the SPI slave front end and the PWM bank.
interface pwm_bank_shadowed_if;
    logic [5:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic [7:0] reg_rdata;

    modport master (output reg_addr, output reg_wdata, output reg_wr, input reg_rdata);
    modport slave  (input reg_addr, input reg_wdata, input reg_wr, output reg_rdata);
endinterface

// File: rtl/pwm_bank_shadowed.sv
// N-channel PWM bank with byte-wide register file and double-buffered period/duty.
// Staging registers are copied into per-channel active copies at start and at each period boundary.
module pwm_bank_shadowed #(
    parameter int unsigned NCH       = 4,
    parameter int unsigned CNT_BYTES = 2,
    parameter logic [7:0]  ID_VAL    = 8'hA5
) (
    input  logic                clk,
    input  logic                rst_n,
    pwm_bank_shadowed_if.slave  bus,
    input  logic [NCH-1:0]      ext_start,
    output logic [NCH-1:0]      pwm_out,
    output logic [NCH-1:0]      period_end
);
    localparam int unsigned CNT_W = 8 * CNT_BYTES;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [NCH-1:0]   ctrl_q;
    logic [NCH-1:0]   pol_q;
    logic [NCH-1:0]   en_c;
    logic [NCH-1:0]   status_c;
    logic [NCH-1:0]   state_q;
    logic [NCH-1:0]   state_d;
    logic [NCH-1:0]   pwm_q;
    logic [NCH-1:0]   pe_q;
    logic [CNT_W-1:0] per_stg_q  [NCH];
    logic [CNT_W-1:0] duty_stg_q [NCH];
    logic [CNT_W-1:0] per_act_q  [NCH];
    logic [CNT_W-1:0] duty_act_q [NCH];
    logic [CNT_W-1:0] cnt_q      [NCH];

    assign en_c       = ctrl_q | ext_start;
    assign pwm_out    = pwm_q;
    assign period_end = pe_q;

    // Software-visible staging registers; always writable, even while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            pol_q  <= '0;
            for (int c = 0; c < NCH; c++) begin
                per_stg_q[c]  <= '0;
                duty_stg_q[c] <= '0;
            end
        end else if (bus.reg_wr) begin
            if (bus.reg_addr == 6'd1) ctrl_q <= bus.reg_wdata[NCH-1:0];
            if (bus.reg_addr == 6'd2) pol_q  <= bus.reg_wdata[NCH-1:0];
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < CNT_BYTES; k++) begin
                    if (bus.reg_addr == 6'(8 * (c + 1) + k))
                        per_stg_q[c][8*k +: 8] <= bus.reg_wdata;
                    if (bus.reg_addr == 6'(8 * (c + 1) + 4 + k))
                        duty_stg_q[c][8*k +: 8] <= bus.reg_wdata;
                end
            end
        end
    end

    // Per-channel run state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= {NCH{ST_IDLE}};
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        status_c = '0;
        for (int c = 0; c < NCH; c++) begin
            status_c[c] = (state_q[c] == ST_RUN);
            if (en_c[c]) state_d[c] = ST_RUN;
            else         state_d[c] = ST_IDLE;
        end
    end

    // Counters, active copies and registered outputs; idle/start cycles drive the inactive level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= '0;
            pe_q  <= '0;
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c]      <= '0;
                per_act_q[c]  <= '0;
                duty_act_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                pe_q[c]  <= 1'b0;
                pwm_q[c] <= pol_q[c];
                if (!en_c[c]) begin
                    cnt_q[c] <= '0;
                end else if (state_q[c] == ST_IDLE) begin
                    cnt_q[c]      <= '0;
                    per_act_q[c]  <= per_stg_q[c];
                    duty_act_q[c] <= duty_stg_q[c];
                end else if (per_act_q[c] != '0) begin
                    pwm_q[c] <= (cnt_q[c] < duty_act_q[c]) ^ pol_q[c];
                    if (cnt_q[c] == per_act_q[c] - CNT_W'(1)) begin
                        cnt_q[c]      <= '0;
                        pe_q[c]       <= 1'b1;
                        per_act_q[c]  <= per_stg_q[c];
                        duty_act_q[c] <= duty_stg_q[c];
                    end else begin
                        cnt_q[c] <= cnt_q[c] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Readback returns staging values, never the active copies
    always_comb begin
        bus.reg_rdata = '0;
        case (bus.reg_addr)
            6'd0: bus.reg_rdata = ID_VAL;
            6'd1: bus.reg_rdata = 8'(ctrl_q);
            6'd2: bus.reg_rdata = 8'(pol_q);
            6'd3: bus.reg_rdata = 8'(status_c);
            default: begin
                for (int c = 0; c < NCH; c++) begin
                    for (int k = 0; k < CNT_BYTES; k++) begin
                        if (bus.reg_addr == 6'(8 * (c + 1) + k))
                            bus.reg_rdata = per_stg_q[c][8*k +: 8];
                        if (bus.reg_addr == 6'(8 * (c + 1) + 4 + k))
                            bus.reg_rdata = duty_stg_q[c][8*k +: 8];
                    end
                end
            end
        endcase
    end
endmodule

// File: tb/tb_pwm_bank_shadowed.sv
// Bench for pwm_bank_shadowed: directed tables plus randomized traffic against a waveform-queue model.
module tb_pwm_bank_shadowed;
    localparam int unsigned NCH       = 4;
    localparam int unsigned CNT_BYTES = 3;
    localparam logic [7:0]  ID_VAL    = 8'hA5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] ext_start;
    logic [NCH-1:0] pwm_out;
    logic [NCH-1:0] period_end;

    pwm_bank_shadowed_if bus();

    pwm_bank_shadowed #(.NCH(NCH), .CNT_BYTES(CNT_BYTES), .ID_VAL(ID_VAL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .ext_start  (ext_start),
        .pwm_out    (pwm_out),
        .period_end (period_end)
    );

    always #10 clk = ~clk;

    typedef struct {
        int unsigned per;
        int unsigned duty;
        logic        pol;
        int unsigned exp_hi;
        int unsigned exp_pe;
    } edge_vec_t;

    typedef struct {
        logic [5:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    int nvec;
    int nfail;

    // Model: each running channel holds the remaining samples {active, last} of its current period
    logic [NCH-1:0] m_ctrl, m_pol, m_run, m_stuck, e_pwm, e_pe;
    int unsigned    m_per  [NCH];
    int unsigned    m_duty [NCH];
    logic [1:0]     wave_q [NCH][$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_ctrl = '0; m_pol = '0; m_run = '0; m_stuck = '0; e_pwm = '0; e_pe = '0;
        for (int c = 0; c < NCH; c++) begin
            m_per[c] = 0; m_duty[c] = 0;
            wave_q[c].delete();
        end
    endfunction

    function automatic void load_period(int c);
        int unsigned p = m_per[c];
        int unsigned d = m_duty[c];
        wave_q[c].delete();
        m_stuck[c] = (p == 0);
        for (int unsigned i = 0; i < p; i++) wave_q[c].push_back({i < d, i == p - 1});
    endfunction

    function automatic void model_write(logic [5:0] a, logic [7:0] d);
        if (a == 6'd1) m_ctrl = d[NCH-1:0];
        else if (a == 6'd2) m_pol = d[NCH-1:0];
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < CNT_BYTES; k++) begin
                if (int'(a) == 8 * (c + 1) + k)     m_per[c][8*k +: 8]  = d;
                if (int'(a) == 8 * (c + 1) + 4 + k) m_duty[c][8*k +: 8] = d;
            end
    endfunction

    function automatic logic [7:0] model_read(logic [5:0] a);
        if (a == 6'd0) return ID_VAL;
        if (a == 6'd1) return 8'(m_ctrl);
        if (a == 6'd2) return 8'(m_pol);
        if (a == 6'd3) return 8'(m_run);
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < CNT_BYTES; k++) begin
                if (int'(a) == 8 * (c + 1) + k)     return m_per[c][8*k +: 8];
                if (int'(a) == 8 * (c + 1) + 4 + k) return m_duty[c][8*k +: 8];
            end
        return 8'h00;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven
    function automatic void model_edge();
        logic [NCH-1:0] en = m_ctrl | ext_start;
        logic [1:0] w;
        for (int c = 0; c < NCH; c++) begin
            e_pe[c]  = 1'b0;
            e_pwm[c] = m_pol[c];
            if (!en[c]) begin
                m_run[c] = 1'b0; m_stuck[c] = 1'b0;
                wave_q[c].delete();
            end else if (!m_run[c]) begin
                m_run[c] = 1'b1;
                load_period(c);
            end else if (!m_stuck[c]) begin
                w = wave_q[c].pop_front();
                e_pwm[c] = w[1] ^ m_pol[c];
                e_pe[c]  = w[0];
                if (wave_q[c].size() == 0) load_period(c);
            end
        end
        if (bus.reg_wr) model_write(bus.reg_addr, bus.reg_wdata);
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("pwm_out", 32'(pwm_out), 32'(e_pwm));
        check("period_end", 32'(period_end), 32'(e_pe));
    endtask

    task automatic wr(logic [5:0] a, logic [7:0] d);
        bus.reg_addr = a; bus.reg_wdata = d; bus.reg_wr = 1'b1;
        tick();
        bus.reg_wr = 1'b0;
    endtask

    task automatic rd(string name, logic [5:0] a);
        bus.reg_addr = a;
        #1;
        check(name, 32'(bus.reg_rdata), 32'(model_read(a)));
    endtask

    task automatic wr_ch(int c, int unsigned per, int unsigned duty);
        for (int k = 0; k < CNT_BYTES; k++) begin
            wr(6'(8 * (c + 1) + k), 8'(per >> (8 * k)));
            wr(6'(8 * (c + 1) + 4 + k), 8'(duty >> (8 * k)));
        end
    endtask

    edge_vec_t tbl [8];
    rd_vec_t   rst_tbl [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned hi, pe, r, sel;
        logic [5:0] a;
        logic [7:0] d;
        logic found;

        tbl[0] = '{10,  3, 1'b0,  9, 3};
        tbl[1] = '{10,  3, 1'b1, 21, 3};
        tbl[2] = '{10,  0, 1'b0,  0, 3};
        tbl[3] = '{10,  0, 1'b1, 30, 3};
        tbl[4] = '{10, 12, 1'b0, 30, 3};
        tbl[5] = '{10, 12, 1'b1,  0, 3};
        tbl[6] = '{ 0,  5, 1'b0,  0, 0};
        tbl[7] = '{ 0,  5, 1'b1, 30, 0};
        rst_tbl[0] = '{6'd0,  8'hA5};
        rst_tbl[1] = '{6'd1,  8'h00};
        rst_tbl[2] = '{6'd2,  8'h00};
        rst_tbl[3] = '{6'd3,  8'h00};
        rst_tbl[4] = '{6'd8,  8'h00};
        rst_tbl[5] = '{6'd10, 8'h00};
        rst_tbl[6] = '{6'd12, 8'h00};

        nvec = 0; nfail = 0;
        bus.reg_addr = '0; bus.reg_wdata = '0; bus.reg_wr = 1'b0;
        ext_start = '0; rst_n = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_pwm", 32'(pwm_out), 32'h0);
        check("rst_pe", 32'(period_end), 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus.reg_addr = rst_tbl[i].addr;
            #1;
            check($sformatf("rst_rd%0d", rst_tbl[i].addr), 32'(bus.reg_rdata), 32'(rst_tbl[i].exp));
        end
        rst_n = 1'b1;
        #1;

        // Basic run on ch0: PERIOD=10 DUTY=3
        wr_ch(0, 10, 3);
        wr(6'd1, 8'h01);
        tick();
        hi = 0; pe = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            hi += 32'(pwm_out[0]);
            pe += 32'(period_end[0]);
        end
        check("basic_hi", hi, 6);
        check("basic_pe", pe, 2);
        rd("basic_status", 6'd3);
        check("basic_status_bit", 32'(bus.reg_rdata[0]), 32'h1);

        // Shadow update: duty change mid-period applies from the next period
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = period_end[0];
        end
        check("shadow_wait_pe", 32'(found), 32'h1);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) wr(6'd12, 8'd7);
            else tick();
            hi += 32'(pwm_out[0]);
        end
        check("shadow_cur_hi", hi, 3);
        check("shadow_cur_pe", 32'(period_end[0]), 32'h1);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            hi += 32'(pwm_out[0]);
        end
        check("shadow_next_hi", hi, 7);
        rd("shadow_rd_duty", 6'd12);

        // Boundary cases table on ch0
        for (int i = 0; i < 8; i++) begin
            wr(6'd1, 8'h00);
            wr_ch(0, tbl[i].per, tbl[i].duty);
            wr(6'd2, {7'b0, tbl[i].pol});
            wr(6'd1, 8'h01);
            tick();
            hi = 0; pe = 0;
            for (int j = 0; j < 30; j++) begin
                tick();
                hi += 32'(pwm_out[0]);
                pe += 32'(period_end[0]);
            end
            check($sformatf("edge%0d_hi", i), hi, tbl[i].exp_hi);
            check($sformatf("edge%0d_pe", i), pe, tbl[i].exp_pe);
        end

        // Multi-channel: ch1 via ext_start, ch2 via CTRL
        wr(6'd1, 8'h00);
        wr(6'd2, 8'h00);
        wr_ch(1, 5, 2);
        wr_ch(2, 8, 5);
        ext_start = 4'b0010;
        wr(6'd1, 8'h04);
        for (int i = 0; i < 40; i++) tick();
        rd("multi_status", 6'd3);
        check("multi_status_bits", 32'(bus.reg_rdata[2:1]), 32'h3);
        ext_start = '0;
        tick();
        check("multi_ch1_stop", 32'(pwm_out[1]), 32'h0);
        rd("multi_status2", 6'd3);
        check("multi_status2_bits", 32'(bus.reg_rdata[2:1]), 32'h2);
        for (int i = 0; i < 10; i++) tick();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) ext_start = NCH'($urandom);
            if (r <= 3) begin
                sel = $urandom_range(0, 6);
                d = 8'($urandom);
                case (sel)
                    0: a = 6'd1;
                    1: a = 6'd2;
                    2: a = 6'($urandom_range(0, 1) * 3);
                    3: a = 6'($urandom_range(4, 7));
                    default: begin
                        int c = $urandom_range(0, NCH - 1);
                        int k = $urandom_range(0, 3);
                        a = 6'(8 * (c + 1) + 4 * $urandom_range(0, 1) + k);
                        if (k == 0) d = 8'($urandom_range(0, 12));
                        else if (k < CNT_BYTES) d = ($urandom_range(0, 7) == 0 && k == 1) ? 8'd1 : 8'd0;
                    end
                endcase
                wr(a, d);
            end else begin
                tick();
            end
            if ($urandom_range(0, 3) == 0) rd("rand_rd", 6'($urandom_range(0, 63)));
        end

        // Asynchronous reset mid-period with a long 24-bit period
        ext_start = '0;
        wr(6'd1, 8'h00);
        wr(6'd2, 8'h00);
        wr_ch(0, 32'h010000, 32'h008000);
        wr(6'd1, 8'h01);
        for (int i = 0; i < 100; i++) tick();
        check("long_run_hi", 32'(pwm_out[0]), 32'h1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_pwm", 32'(pwm_out), 32'h0);
        check("arst_pe", 32'(period_end), 32'h0);
        for (int i = 0; i < 7; i++) begin
            bus.reg_addr = rst_tbl[i].addr;
            #1;
            check($sformatf("arst_rd%0d", rst_tbl[i].addr), 32'(bus.reg_rdata), 32'(rst_tbl[i].exp));
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) tick();
        rd("arst_idle_status", 6'd3);
        check("arst_idle_pwm", 32'(pwm_out), 32'h0);
        wr(6'd1, 8'h01);
        for (int i = 0; i < 10; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
